// File: rtl/ulpi_reg_link.sv
// ulpi_reg_link: ULPI link-side register read/write engine with RX CMD snooping
// Ports: clk, rst (sync, active-high); ulpi_dir/nxt/data_in from PHY, ulpi_data_out/oe/stp to PHY;
// reg_en/we/addr/din request in, reg_rdy/dout/err completion out; line_state/vbus_state from RX CMD.
// Optional macro ULPI_EXT_REG_EN: addresses above 8'h3F use the extended-address sequence via EXT_ADDR.
module ulpi_reg_link #(
  parameter int TURNAROUND_CYCLES = 1,
  parameter int MAX_RETRY = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ulpi_dir,
  input  logic       ulpi_nxt,
  input  logic [7:0] ulpi_data_in,
  output logic [7:0] ulpi_data_out,
  output logic       ulpi_data_oe,
  output logic       ulpi_stp,
  input  logic       reg_en,
  input  logic       reg_we,
  input  logic [7:0] reg_addr,
  input  logic [7:0] reg_din,
  output logic       reg_rdy,
  output logic [7:0] reg_dout,
  output logic       reg_err,
  output logic [1:0] line_state,
  output logic [1:0] vbus_state
);
  localparam logic [3:0] IDLE = 4'd0, CMD = 4'd1, WR_DATA = 4'd2, WR_STP = 4'd3,
                         RD_TA = 4'd4, RD_DATA = 4'd5, RD_WAIT = 4'd6, RETRY = 4'd7;
  logic [3:0] state, state_n, after_cmd, after_addr;
  logic       we, dir_q, ta, drive, abort, give_up, rx_cmd, in_ext;
  logic [7:0] addr, din, ta_cnt, retry_cnt;
  logic [5:0] cmd_lo;
  assign after_addr = we ? WR_DATA : RD_TA;
`ifdef ULPI_EXT_REG_EN
  localparam logic [3:0] EXT_ADDR = 4'd8;
  // extended registers go out as the 6'h2F escape followed by the full address byte
  assign cmd_lo = addr > 8'h3F ? 6'h2F : addr[5:0];
  assign after_cmd = addr > 8'h3F ? EXT_ADDR : after_addr;
  assign in_ext = state == EXT_ADDR;
`else
  assign cmd_lo = addr[5:0];
  assign after_cmd = after_addr;
  assign in_ext = 1'b0;
`endif
  // the cycle of a dir edge plus any extra configured cycles are bus turnaround
  assign ta = (ulpi_dir != dir_q) || (ta_cnt != 8'd0);
  assign drive = (state inside {CMD, WR_DATA, WR_STP}) || in_ext;
  assign ulpi_data_oe = drive && !ulpi_dir && !ta;
  assign ulpi_stp = state == WR_STP;
  assign ulpi_data_out = state == CMD ? {1'b1, ~we, cmd_lo} : state == WR_DATA ? din : in_ext ? addr : 8'h00;
  // PHY grabbing the bus mid-command, or answering a read turnaround with nxt, kills the attempt
  assign abort = ulpi_dir && ((state inside {CMD, WR_DATA}) || in_ext || (state == RD_TA && ulpi_nxt));
  assign give_up = abort && retry_cnt == 8'(MAX_RETRY - 1);
  assign rx_cmd = ulpi_dir && !ulpi_nxt && !ta && state != RD_DATA;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = reg_en ? ((ulpi_dir || ta) ? RETRY : CMD) : IDLE;
      CMD: state_n = ulpi_nxt ? after_cmd : CMD;
`ifdef ULPI_EXT_REG_EN
      EXT_ADDR: state_n = ulpi_nxt ? after_addr : EXT_ADDR;
`endif
      WR_DATA: state_n = ulpi_nxt ? WR_STP : WR_DATA;
      WR_STP: state_n = IDLE;
      RD_TA: state_n = ulpi_dir ? RD_DATA : RD_TA;
      RD_DATA: state_n = RD_WAIT;
      RD_WAIT: state_n = ulpi_dir ? RD_WAIT : IDLE;
      RETRY: state_n = (ulpi_dir || ta) ? RETRY : CMD;
      default: state_n = IDLE;
    endcase
    if (abort) state_n = give_up ? IDLE : RETRY;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      dir_q <= 1'b0;
      ta_cnt <= 8'd0;
      retry_cnt <= 8'd0;
      we <= 1'b0;
      addr <= 8'h00;
      din <= 8'h00;
      reg_rdy <= 1'b0;
      reg_err <= 1'b0;
      reg_dout <= 8'h00;
      line_state <= 2'b00;
      vbus_state <= 2'b00;
    end else begin
      state <= state_n;
      dir_q <= ulpi_dir;
      ta_cnt <= (ulpi_dir != dir_q) ? 8'(TURNAROUND_CYCLES - 1) : ta_cnt - {7'd0, ta_cnt != 8'd0};
      if (state == IDLE && reg_en) begin
        we <= reg_we;
        addr <= reg_addr;
        din <= reg_din;
        retry_cnt <= 8'd0;
      end else if (abort) retry_cnt <= retry_cnt + 8'd1;
      reg_rdy <= state == WR_STP || state == RD_DATA || give_up;
      reg_err <= give_up;
      if (state == RD_DATA) reg_dout <= ulpi_data_in;
      if (rx_cmd) {vbus_state, line_state} <= ulpi_data_in[3:0];
    end
  end
endmodule

// File: tb/tb_ulpi_reg_link.sv
// tb_ulpi_reg_link: directed and randomized register/RX CMD traffic against a transaction-level PHY model
module tb_ulpi_reg_link;
  logic clk = 1'b0, rst = 1'b1, dir = 1'b0, nxt = 1'b0, en = 1'b0, we = 1'b0;
  logic [7:0] bus_in = 8'h00, addr = 8'h00, wdata = 8'h00;
  logic [7:0] data_out, dout;
  logic oe, stp, rdy, err;
  logic [1:0] line, vbus;
  int tests = 0, fails = 0;
  logic [7:0] m_dout = 8'h00;
  logic [3:0] m_rx = 4'h0;
`ifdef ULPI_EXT_REG_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif
  always #5 clk = ~clk;
  ulpi_reg_link dut (
    .clk(clk), .rst(rst), .ulpi_dir(dir), .ulpi_nxt(nxt), .ulpi_data_in(bus_in),
    .ulpi_data_out(data_out), .ulpi_data_oe(oe), .ulpi_stp(stp),
    .reg_en(en), .reg_we(we), .reg_addr(addr), .reg_din(wdata),
    .reg_rdy(rdy), .reg_dout(dout), .reg_err(err), .line_state(line), .vbus_state(vbus)
  );
  function automatic logic [7:0] r8();
    return 8'($urandom);
  endfunction
  function automatic logic [7:0] cmd_byte(input logic w, input logic [7:0] a);
    return {1'b1, ~w, (EXT && a > 8'h3F) ? 6'h2F : a[5:0]};
  endfunction
  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask
  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask
  task automatic bus(input logic d, input logic n, input logic [7:0] x);
    dir = d;
    nxt = n;
    bus_in = x;
    #1;
  endtask
  task automatic check_model();
    chk8("rx_state", {4'd0, vbus, line}, {4'd0, m_rx});
    chk8("dout_hold", dout, m_dout);
    chk1("rdy_quiet", rdy, 1'b0);
  endtask
  task automatic request(input logic w, input logic [7:0] a, input logic [7:0] d);
    en = 1'b1;
    we = w;
    addr = a;
    wdata = d;
    bus(1'b0, 1'b0, r8());
    chk1("req_rdy", rdy, 1'b0);
    cyc();
    en = 1'b0;
    we = r8() > 8'h7F;
    addr = r8();
    wdata = r8();
  endtask
  task automatic cmd_phase(input logic w, input logic [7:0] a, input int cw);
    for (int i = 0; i <= cw; i++) begin
      bus(1'b0, i == cw, r8());
      chk1("cmd_oe", oe, 1'b1);
      chk8("cmd_byte", data_out, cmd_byte(w, a));
      chk1("cmd_rdy", rdy, 1'b0);
      cyc();
    end
    if (EXT && a > 8'h3F) begin
      bus(1'b0, 1'b1, r8());
      chk1("ext_oe", oe, 1'b1);
      chk8("ext_addr", data_out, a);
      cyc();
    end
  endtask
  task automatic wr_tail(input logic [7:0] d, input int dw);
    for (int i = 0; i <= dw; i++) begin
      bus(1'b0, i == dw, r8());
      chk1("wr_oe", oe, 1'b1);
      chk8("wr_data", data_out, d);
      chk1("wr_nostp", stp, 1'b0);
      cyc();
    end
    bus(1'b0, 1'b0, r8());
    chk1("stp", stp, 1'b1);
    chk8("stp_data", data_out, 8'h00);
    chk1("stp_rdy", rdy, 1'b0);
    cyc();
    bus(1'b0, 1'b0, r8());
    chk1("wr_rdy", rdy, 1'b1);
    chk1("wr_err", err, 1'b0);
    chk1("wr_stp_off", stp, 1'b0);
    cyc();
    check_model();
  endtask
  task automatic do_write(input logic [7:0] a, input logic [7:0] d, input int cw, input int dw);
    request(1'b1, a, d);
    cmd_phase(1'b1, a, cw);
    wr_tail(d, dw);
  endtask
  task automatic do_read(input logic [7:0] a, input logic [7:0] r, input int cw);
    request(1'b0, a, r8());
    cmd_phase(1'b0, a, cw);
    bus(1'b0, 1'b0, r8());
    chk1("rd_ta_rdy", rdy, 1'b0);
    cyc();
    bus(1'b1, 1'b0, r8());
    chk1("rd_oe", oe, 1'b0);
    cyc();
    bus(1'b1, 1'b0, r);
    chk1("rd_data_rdy", rdy, 1'b0);
    cyc();
    m_dout = r;
    bus(1'b0, 1'b0, r8());
    chk1("rd_rdy", rdy, 1'b1);
    chk1("rd_err", err, 1'b0);
    chk8("rd_dout", dout, r);
    cyc();
    check_model();
  endtask
  task automatic rx_cmd(input logic [7:0] b);
    bus(1'b1, 1'b0, r8());
    cyc();
    bus(1'b1, 1'b0, b);
    cyc();
    m_rx = b[3:0];
    bus(1'b0, 1'b0, r8());
    check_model();
    cyc();
    bus(1'b0, 1'b0, r8());
    cyc();
  endtask
  task automatic packet(input logic [7:0] b, input int n);
    bus(1'b1, 1'b1, r8());
    cyc();
    for (int i = 0; i < n; i++) begin
      bus(1'b1, 1'b1, b);
      cyc();
    end
    bus(1'b0, 1'b0, r8());
    check_model();
    cyc();
    bus(1'b0, 1'b0, r8());
    cyc();
  endtask
  initial begin
    logic [7:0] a, d;
    bus(1'b0, 1'b0, 8'h00);
    repeat (3) cyc();
    chk1("rst_oe", oe, 1'b0);
    chk1("rst_stp", stp, 1'b0);
    chk8("rst_data", data_out, 8'h00);
    chk1("rst_err", err, 1'b0);
    check_model();
    rst = 1'b0;
    cyc();
    do_write(8'h0A, 8'h00, 0, 0);
    do_read(8'h04, 8'h45, 0);
    request(1'b1, 8'h04, 8'h49);
    bus(1'b0, 1'b0, r8());
    chk1("ab_pre_oe", oe, 1'b1);
    chk8("ab_pre_cmd", data_out, 8'h84);
    bus(1'b1, 1'b0, 8'h0F);
    chk1("ab_oe", oe, 1'b0);
    cyc();
    bus(1'b1, 1'b0, 8'h0F);
    cyc();
    m_rx = 4'hF;
    bus(1'b0, 1'b0, r8());
    check_model();
    chk1("ab_wait_oe", oe, 1'b0);
    cyc();
    bus(1'b0, 1'b0, r8());
    chk1("ab_wait2_oe", oe, 1'b0);
    chk1("ab_wait2_rdy", rdy, 1'b0);
    cyc();
    cmd_phase(1'b1, 8'h04, 0);
    wr_tail(8'h49, 0);
    a = r8() & 8'h3F;
    d = r8();
    request(1'b1, a, d);
    for (int k = 1; k <= 7; k++) begin
      bus(1'b0, 1'b0, r8());
      chk1("gu_oe", oe, 1'b1);
      chk8("gu_cmd", data_out, cmd_byte(1'b1, a));
      bus(1'b1, 1'b0, r8());
      chk1("gu_drop", oe, 1'b0);
      chk1("gu_stp", stp, 1'b0);
      cyc();
      if (k < 7) begin
        bus(1'b0, 1'b0, r8());
        chk1("gu_rdy", rdy, 1'b0);
        chk1("gu_stp2", stp, 1'b0);
        cyc();
        bus(1'b0, 1'b0, r8());
        chk1("gu_idle_oe", oe, 1'b0);
        cyc();
      end
    end
    bus(1'b0, 1'b0, r8());
    chk1("gu_final_rdy", rdy, 1'b1);
    chk1("gu_final_err", err, 1'b1);
    chk8("gu_dout", dout, m_dout);
    chk1("gu_final_stp", stp, 1'b0);
    cyc();
    check_model();
    rx_cmd(8'h00);
    rx_cmd(8'h0D);
    packet(8'hFF, 2);
    do_write(8'h80, 8'h5A, 0, 0);
    do_read(8'hC5, 8'h3C, 1);
    request(1'b1, r8() & 8'h3F, r8());
    bus(1'b0, 1'b1, r8());
    cyc();
    bus(1'b0, 1'b0, r8());
    chk1("rst_mid_oe", oe, 1'b1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    m_rx = 4'h0;
    m_dout = 8'h00;
    bus(1'b0, 1'b0, r8());
    chk1("rst_mid_oe0", oe, 1'b0);
    chk1("rst_mid_stp", stp, 1'b0);
    check_model();
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk1("rst_after_rdy", rdy, 1'b0);
      chk1("rst_after_oe", oe, 1'b0);
    end
    cyc();
    repeat (30) begin
      case ($urandom_range(0, 3))
        0: do_write(r8(), r8(), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        1: do_read(r8(), r8(), int'($urandom_range(0, 2)));
        2: rx_cmd(r8());
        default: packet(r8(), int'($urandom_range(1, 3)));
      endcase
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ulpi_reg_link.md
Name: ulpi_reg_link

Overview:
ULPI link-side engine between the USB state controller and the external ULPI PHY. It turns single-cycle register read/write requests (reg_en/reg_we/reg_addr/reg_din) into ULPI TX CMD sequences and returns completion as reg_rdy/reg_dout. It also decodes PHY RX CMD bytes into line_state and vbus_state for the state controller. Packet TX/RX data paths are out of scope; this block owns the bus only for register access and RX CMD snooping.

Parameters:
TURNAROUND_CYCLES, 1, bus turnaround cycles ignored after every ulpi_dir edge.
MAX_RETRY, 7, PHY-abort retries per request before reporting completion with reg_err.

Ports:
clk  in  1  60 MHz ULPI clock
rst  in  1  reset; synchronous, active-high
ulpi_dir  in  1  PHY owns bus when 1
ulpi_nxt  in  1  PHY throttle/accept
ulpi_data_in  in  8  bus data from PHY
ulpi_data_out  out  8  bus data to PHY
ulpi_data_oe  out  1  link drives bus
ulpi_stp  out  1  link stop strobe
reg_en  in  1  request strobe, one cycle
reg_we  in  1  1 = write, 0 = read (valid with reg_en)
reg_addr  in  8  register address (valid with reg_en)
reg_din  in  8  write data (valid with reg_en)
reg_rdy  out  1  one-cycle completion pulse
reg_dout  out  8  read data, valid from reg_rdy until next completion
reg_err  out  1  valid with reg_rdy; 1 = retries exhausted
line_state  out  2  RX CMD bits [1:0]
vbus_state  out  2  RX CMD bits [3:2]

Behaviour:
- Reset values: ulpi_data_out=0, ulpi_data_oe=0, ulpi_stp=0, reg_rdy=0, reg_dout=0, reg_err=0, line_state=0, vbus_state=0, FSM=IDLE, retry count=0. Reset mid-transfer abandons the transfer with no reg_rdy and releases the bus the next cycle.
- Request acceptance: reg_en is sampled only in IDLE. reg_we, reg_addr and reg_din are latched on that cycle. reg_en outside IDLE is ignored; upstream keeps one request outstanding.
- The link never drives the bus while ulpi_dir=1. ulpi_data_oe is the registered drive flag ANDed combinationally with ~ulpi_dir.
- Turnaround: for TURNAROUND_CYCLES cycles after any ulpi_dir edge, ulpi_data_in is ignored and ulpi_data_oe=0.
- FSM states and transitions:
  - IDLE: on accept with ulpi_dir=0, go to CMD.
  - CMD: drive {2'b10 (write) or 2'b11 (read), addr[5:0]}. When ulpi_nxt=1, go to WR_DATA (write) or RD_TA (read).
  - WR_DATA: drive din. When ulpi_nxt=1, go to WR_STP.
  - WR_STP: ulpi_stp=1 and data_out=0 for exactly one cycle. Then pulse reg_rdy and return to IDLE.
  - RD_TA: wait for ulpi_dir=1 (turnaround cycle), then go to RD_DATA.
  - RD_DATA: capture ulpi_data_in into reg_dout, pulse reg_rdy, go to RD_WAIT.
  - RD_WAIT: return to IDLE when ulpi_dir=0.
- Latency for an immediately-accepting PHY: write = 4 cycles from reg_en to reg_rdy; read = 5 cycles.
- PHY abort: ulpi_dir rising during CMD or WR_DATA, or ulpi_nxt=1 in the first dir=1 cycle of a read, means the PHY took the bus for RX.
  - Release the bus immediately and go to RETRY.
  - RETRY waits for ulpi_dir=0 plus turnaround, then re-enters CMD.
  - After MAX_RETRY aborts, pulse reg_rdy with reg_err=1 and return to IDLE; reg_dout is unchanged.
- RX CMD decode: a cycle with ulpi_dir=1, ulpi_nxt=0, not a turnaround cycle and not RD_DATA is an RX CMD. Update line_state<=data[1:0] and vbus_state<=data[3:2] the following cycle. dir=1 with nxt=1 is packet data and is ignored.
- Simultaneous events:
  - reg_en in the same cycle ulpi_dir rises: the request is latched and held until dir=0 plus turnaround.
  - RX CMD during RETRY or RD_WAIT still updates line_state and vbus_state.

Optional Feature:
ULPI_EXT_REG_EN.
- Defined, addr>8'h3F (write): CMD drives {2'b10,6'h2F}, then an EXT_ADDR state drives the full addr and waits for nxt, then WR_DATA. Latency is +1 cycle.
- Defined, addr>8'h3F (read): CMD drives {2'b11,6'h2F}, then EXT_ADDR, then RD_TA. Latency is +1 cycle.
- Undefined: only addr[5:0] is used; upper bits are ignored. No EXT_ADDR state exists.

Test Plan:
1. Write addr 8'h0A din 8'h00, PHY asserts nxt immediately -> bus shows 8'h8A, 8'h00, then stp=1 with data 0 for one cycle; reg_rdy pulses 4 cycles after reg_en; reg_err=0.
2. Read addr 8'h04, PHY returns 8'h45 after turnaround -> CMD 8'hC4; oe drops when dir rises; reg_dout=8'h45 with reg_rdy 5 cycles after reg_en.
3. Write 8'h04/8'h49 with PHY raising dir (nxt=0, data 8'h0F) during CMD -> oe=0 in the same cycle; line_state=2'b11 and vbus_state=2'b11 one cycle later; after dir=0 plus 1 cycle, CMD reissued; single reg_rdy, reg_err=0.
4. PHY aborts every attempt of a write -> after 7 aborts, reg_rdy=1 with reg_err=1; no stp ever driven.
5. RX CMD stream 8'h00, then 8'h0D -> line_state 00 then 01 and vbus_state 00 then 11; a dir=1/nxt=1 byte 8'hFF leaves both unchanged.
6. rst asserted in WR_DATA -> next cycle oe=0, stp=0, no reg_rdy. With ULPI_EXT_REG_EN defined, write addr 8'h80 -> bus 8'hAF, 8'h80, din, stp.
